display_scan_controller: RTL and testbench

- Time-multiplexes four 7-segment digit patterns onto the shared 4-anode display of the step motor board.
- Sits between the per-digit segment decoders (speed/number to segment) and the board pins; drives anodes and segments.
- Scans only enabled digits, inserts a blanking gap between digits to suppress ghosting, and accepts new display content only at frame boundaries (req/ack) so frames never tear.

---
 rtl/display_scan_controller.sv | 157 +++++++++++++++
 tb/tb_display_scan_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Time-multiplexes four active-low 7-segment patterns onto a shared 4-anode display.
// New content is accepted only at frame boundaries so a frame never mixes old and new patterns.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_IDLE  | nothing enabled; display dark, waiting for an update
//   S_BLANK | start of a digit slot, all anodes off (anti-ghosting)
//   S_SHOW  | remainder of the slot, digit ptr driven
module display_scan_controller #(
  parameter int DIVIDE = 100000,
  parameter int BLANK  = 1000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [27:0] digitSeg,
  input  logic [3:0]  digitEn,
  input  logic        updateReq,
  output logic        updateAck,
  output logic [3:0]  anode,
  output logic [6:0]  segOut,
  output logic        frameTick
);

  localparam int CW = $clog2(DIVIDE);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIVIDE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  localparam state_t SLOT_FIRST = (BLANK == 0) ? S_SHOW : S_BLANK;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [3:0]     shadow_en_q, shadow_en_d;
  logic [27:0]    shadow_seg_q, shadow_seg_d;
  logic [3:0]     anode_q, anode_d;
  logic [6:0]     seg_out_q, seg_out_d;
  logic           ack_q, tick_q, tick_d;
  logic           load;
  logic [1:0]     next_idx;

  function automatic logic [1:0] lowest_idx(input logic [3:0] en);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (en[i]) lowest_idx = 2'(i);
    end
  endfunction

  // Searches ptr+1..ptr+3 (smallest offset wins); falls back to ptr itself.
  function automatic logic [1:0] next_enabled(input logic [3:0] en, input logic [1:0] p);
    logic [1:0] idx;
    next_enabled = p;
    for (int i = 3; i >= 1; i--) begin
      idx = p + 2'(i);
      if (en[idx]) next_enabled = idx;
    end
  endfunction

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      ptr_q        <= 2'd0;
      count_q      <= '0;
      shadow_en_q  <= 4'h0;
      shadow_seg_q <= {4{7'h7F}};
      anode_q      <= 4'hF;
      seg_out_q    <= 7'h7F;
      ack_q        <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      shadow_en_q  <= shadow_en_d;
      shadow_seg_q <= shadow_seg_d;
      anode_q      <= anode_d;
      seg_out_q    <= seg_out_d;
      ack_q        <= load;
      tick_q       <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    load     = 1'b0;
    tick_d   = 1'b0;
    next_idx = next_enabled(shadow_en_q, ptr_q);
    case (state_q)
      S_IDLE: begin
        if (updateReq) begin
          load = 1'b1;
          if (digitEn != 4'h0) begin
            ptr_d   = lowest_idx(digitEn);
            count_d = '0;
            state_d = SLOT_FIRST;
          end
        end
      end
      S_BLANK: begin
        count_d = count_q + 1'b1;
        if (count_q == BLANK_LAST) state_d = S_SHOW;
      end
      S_SHOW: begin
        if (count_q == DIV_LAST) begin
          count_d = '0;
          state_d = SLOT_FIRST;
          ptr_d   = next_idx;
          // A wrap (or a lone enabled digit) closes the frame: the only point a reload may land.
          if (next_idx <= ptr_q) begin
            tick_d = 1'b1;
            if (updateReq) begin
              load = 1'b1;
              if (digitEn == 4'h0) begin
                state_d = S_IDLE;
                ptr_d   = 2'd0;
              end else begin
                ptr_d = lowest_idx(digitEn);
              end
            end
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_en_d  = load ? digitEn  : shadow_en_q;
    shadow_seg_d = load ? digitSeg : shadow_seg_q;
    anode_d      = 4'hF;
    seg_out_d    = 7'h7F;
    if (state_d == S_SHOW) begin
      anode_d = ~(4'b0001 << ptr_d);
      case (ptr_d)
        2'd0:    seg_out_d = shadow_seg_d[6:0];
        2'd1:    seg_out_d = shadow_seg_d[13:7];
        2'd2:    seg_out_d = shadow_seg_d[20:14];
        default: seg_out_d = shadow_seg_d[27:21];
      endcase
    end
  end

  assign anode     = anode_q;
  assign segOut    = seg_out_q;
  assign updateAck = ack_q;
  assign frameTick = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor pops and compares.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        resetN;
  logic [27:0] digitSeg, b_digitSeg;
  logic [3:0]  digitEn, b_digitEn;
  logic        updateReq, b_updateReq;
  logic        a_ack, a_tick, b_ack, b_tick;
  logic [3:0]  a_an, b_an;
  logic [6:0]  a_seg, b_seg;

  always #5 clk = ~clk;

  display_scan_controller #(.DIVIDE(8), .BLANK(2)) dut (
    .clk(clk), .resetN(resetN), .digitSeg(digitSeg), .digitEn(digitEn),
    .updateReq(updateReq), .updateAck(a_ack), .anode(a_an), .segOut(a_seg),
    .frameTick(a_tick)
  );

  display_scan_controller #(.DIVIDE(8), .BLANK(0)) dut_nb (
    .clk(clk), .resetN(resetN), .digitSeg(b_digitSeg), .digitEn(b_digitEn),
    .updateReq(b_updateReq), .updateAck(b_ack), .anode(b_an), .segOut(b_seg),
    .frameTick(b_tick)
  );

  typedef struct {
    logic       sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       ack;
    logic       tick;
    int         test;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cur_test = 0;
  int   cyc = 0;

  logic [27:0] stage_seg;
  logic [3:0]  stage_en;

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      total++;
      if (mon_e.sel) begin
        if ({b_an, b_seg, b_ack, b_tick} !== {mon_e.an, mon_e.seg, mon_e.ack, mon_e.tick}) begin
          bad++;
          $display("FAIL nb_scan t%0d c%0d: got an=%h seg=%h ack=%b tick=%b, want an=%h seg=%h ack=%b tick=%b",
                   mon_e.test, mon_e.cyc, b_an, b_seg, b_ack, b_tick, mon_e.an, mon_e.seg, mon_e.ack, mon_e.tick);
        end
      end else begin
        if ({a_an, a_seg, a_ack, a_tick} !== {mon_e.an, mon_e.seg, mon_e.ack, mon_e.tick}) begin
          bad++;
          $display("FAIL scan t%0d c%0d: got an=%h seg=%h ack=%b tick=%b, want an=%h seg=%h ack=%b tick=%b",
                   mon_e.test, mon_e.cyc, a_an, a_seg, a_ack, a_tick, mon_e.an, mon_e.seg, mon_e.ack, mon_e.tick);
        end
      end
    end
  end

  function automatic logic [27:0] pack(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [3:0] an_of(input int d);
    case (d)
      0:       return 4'hE;
      1:       return 4'hD;
      2:       return 4'hB;
      default: return 4'h7;
    endcase
  endfunction

  // Queue the outputs expected after the coming edge, then advance to just past the next negedge.
  task automatic step(input logic sel, input logic [3:0] an, input logic [6:0] seg,
                      input logic ack, input logic tick);
    exp_t e;
    e.sel = sel; e.an = an; e.seg = seg; e.ack = ack; e.tick = tick;
    e.test = cur_test; e.cyc = cyc;
    sb_q.push_back(e);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  // One 8-cycle slot on the BLANK=2 instance: 2 dark cycles then 6 showing digit d.
  task automatic slot(input int d, input logic [6:0] sv, input logic ack, input logic tick,
                      input int raise_at);
    for (int c = 0; c < 8; c++) begin
      if (c < 2) step(1'b0, 4'hF, 7'h7F, (c == 0) ? ack : 1'b0, (c == 0) ? tick : 1'b0);
      else       step(1'b0, an_of(d), sv, 1'b0, 1'b0);
      if (c == 0 && ack) updateReq = 1'b0;
      if (c == raise_at) begin
        digitSeg  = stage_seg;
        digitEn   = stage_en;
        updateReq = 1'b1;
      end
    end
  endtask

  // One 8-cycle slot on the BLANK=0 instance: digit d shown the whole slot.
  task automatic slot_nb(input int d, input logic [6:0] sv, input logic ack, input logic tick);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, an_of(d), sv, (c == 0) ? ack : 1'b0, (c == 0) ? tick : 1'b0);
      if (c == 0 && ack) b_updateReq = 1'b0;
    end
  endtask

  initial begin
    resetN      = 1'b0;
    digitSeg    = '0;
    digitEn     = 4'h0;
    updateReq   = 1'b0;
    b_digitSeg  = '0;
    b_digitEn   = 4'h0;
    b_updateReq = 1'b0;
    stage_seg   = '0;
    stage_en    = 4'h0;

    // reset state, then idle with no request
    cur_test = 0;
    step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b0);
    step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b0);
    resetN = 1'b1;
    step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b0);
    step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b0);

    // all four digits, scan 0..3 then wrap with frameTick
    cur_test  = 1;
    digitSeg  = pack(7'h40, 7'h79, 7'h24, 7'h30);
    digitEn   = 4'hF;
    updateReq = 1'b1;
    slot(0, 7'h30, 1'b1, 1'b0, -1);
    slot(1, 7'h24, 1'b0, 1'b0, -1);
    slot(2, 7'h79, 1'b0, 1'b0, -1);
    slot(3, 7'h40, 1'b0, 1'b0, -1);

    // request raised mid-slot on digit 1 stays pending until the wrap
    cur_test  = 3;
    stage_seg = pack(7'h78, 7'h02, 7'h12, 7'h19);
    stage_en  = 4'hF;
    slot(0, 7'h30, 1'b0, 1'b1, -1);
    slot(1, 7'h24, 1'b0, 1'b0, 3);
    slot(2, 7'h79, 1'b0, 1'b0, -1);
    slot(3, 7'h40, 1'b0, 1'b0, -1);
    stage_seg = pack(7'h7F, 7'h10, 7'h7F, 7'h00);
    stage_en  = 4'b0101;
    slot(0, 7'h19, 1'b1, 1'b1, -1);
    slot(1, 7'h12, 1'b0, 1'b0, -1);
    slot(2, 7'h02, 1'b0, 1'b0, -1);
    slot(3, 7'h78, 1'b0, 1'b0, 0);

    // only digits 0 and 2 enabled
    cur_test  = 2;
    stage_seg = pack(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    stage_en  = 4'h0;
    slot(0, 7'h00, 1'b1, 1'b1, -1);
    slot(2, 7'h10, 1'b0, 1'b0, -1);
    slot(0, 7'h00, 1'b0, 1'b1, -1);
    slot(2, 7'h10, 1'b0, 1'b0, 0);

    // zero enables at a boundary -> dark idle, then digit 3 alone
    cur_test = 4;
    step(1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);
    updateReq = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b0);
    digitSeg  = pack(7'h08, 7'h7F, 7'h7F, 7'h7F);
    digitEn   = 4'b1000;
    updateReq = 1'b1;
    slot(3, 7'h08, 1'b1, 1'b0, -1);
    slot(3, 7'h08, 1'b0, 1'b1, -1);
    slot(3, 7'h08, 1'b0, 1'b1, -1);

    // no blanking, single digit 2: anode never goes dark
    cur_test    = 5;
    b_digitSeg  = pack(7'h7F, 7'h46, 7'h7F, 7'h7F);
    b_digitEn   = 4'b0100;
    b_updateReq = 1'b1;
    slot_nb(2, 7'h46, 1'b1, 1'b0);
    slot_nb(2, 7'h46, 1'b0, 1'b1);
    slot_nb(2, 7'h46, 1'b0, 1'b1);

    // async reset mid-SHOW with a request pending
    cur_test = 6;
    step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b1);
    step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b0);
    step(1'b0, 4'h7, 7'h08, 1'b0, 1'b0);
    digitSeg  = pack(7'h40, 7'h79, 7'h24, 7'h30);
    digitEn   = 4'hF;
    updateReq = 1'b1;
    step(1'b0, 4'h7, 7'h08, 1'b0, 1'b0);
    begin
      exp_t e;
      e.sel = 1'b0; e.an = 4'hF; e.seg = 7'h7F; e.ack = 1'b0; e.tick = 1'b0;
      e.test = cur_test; e.cyc = cyc;
      sb_q.push_back(e);
      cyc++;
      @(posedge clk);
      #1 resetN = 1'b0;
      @(negedge clk);
      #1;
    end
    step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b0);
    step(1'b0, 4'hF, 7'h7F, 1'b0, 1'b0);
    resetN = 1'b1;
    slot(0, 7'h30, 1'b1, 1'b0, -1);
    slot(1, 7'h24, 1'b0, 1'b0, -1);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
